// File: rtl/seq_add_pkg.sv
// Shared types for the sequential digit adder: FSM state encoding and the
// digit-counter width helper.
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-digit configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/seq_digit_add_digit_add.sv
// digit_add: combinational DIGIT-bit adder slice with carry out and the carry
// into its most significant bit.
module digit_add #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [DIGIT:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign sum  = full[DIGIT-1:0];
    assign cout = full[DIGIT];
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign msb_cin = full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/seq_digit_add.sv
// seq_digit_add: multi-cycle adder/subtractor, DIGIT bits per clock, LSB first.
// The overflow port and its register exist only when SEQ_ADD_OVF_EN is defined.
module seq_digit_add
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
`ifdef SEQ_ADD_OVF_EN
    output logic             overflow,
`endif
    output state_t           dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("seq_digit_add: WIDTH must be a multiple of DIGIT");
    end

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both high; ready never depends on valid on the same side.
    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
    logic             dig_cout, dig_msb_cin;
    logic             accept, last;

    assign accept = (state == IDLE) && in_valid;
    assign last   = (cnt_q == LAST);
    assign dig_a  = a_q[int'(cnt_q)*DIGIT +: DIGIT];
    assign dig_b  = b_q[int'(cnt_q)*DIGIT +: DIGIT];

    digit_add #(.DIGIT(DIGIT)) u_digit (
        .a       (dig_a),
        .b       (dig_b),
        .cin     (carry_q),
        .sum     (dig_sum),
        .cout    (dig_cout),
        .msb_cin (dig_msb_cin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Subtraction is a + ~b + 1: b is stored inverted and the carry seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
        end else if (state == RUN) begin
            sum_q[int'(cnt_q)*DIGIT +: DIGIT] <= dig_sum;
            carry_q <= dig_cout;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

`ifdef SEQ_ADD_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    ovf_q <= 1'b0;
        else if (state == RUN && last) ovf_q <= dig_msb_cin ^ dig_cout;
    end

    assign overflow = ovf_q;
`else
    logic unused_msb_cin;
    assign unused_msb_cin = dig_msb_cin;
`endif

    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign dbg_state = state;

endmodule

// File: doc/seq_digit_add.md
# seq_digit_add

Parametrised multi-cycle adder/subtractor. It processes two WIDTH-bit operands one DIGIT-bit slice per clock, LSB first, and keeps the carry in a register between slices. It is the successor to the team's combinational ripple adders: width and slice size are parameters, subtraction is supported, and valid/ready handshakes on both sides let it sit in a pipeline next to the datapath's ALU and accumulator blocks.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH % DIGIT != 0 is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a−b, computed as a+~b+1 with cin ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- carry_out  output  1  final carry; for sub=1 this is the not-borrow flag (1 means a>=b unsigned).
- overflow  output  1  signed overflow. Present only with SEQ_ADD_OVF_EN.

## Operation
- NDIG = WIDTH/DIGIT.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a and b, storing b inverted when sub=1. Load the carry register with sub ? 1 : cin. Clear the digit counter. Go to RUN.
  - RUN: each cycle, add digit[cnt] of A and B plus the carry register. Write the DIGIT-bit result into sum slice cnt, update the carry register, and increment cnt. When cnt==NDIG−1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- No input is accepted outside IDLE. Inputs in RUN/DONE are ignored and in_ready=0.
- In DONE, sum, carry_out and overflow are held stable until the result is consumed.
- The final carry register value drives carry_out.
- Arithmetic is modulo 2^WIDTH; no saturation.
- NDIG=1 (DIGIT==WIDTH) is legal: RUN lasts exactly one cycle.
- Reset asserted mid-operation abandons the operation. The state returns to IDLE and all registers clear; no partial result is ever presented.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0, state=IDLE, cnt=0.
- Latency: with operands accepted at edge T, out_valid rises after edge T+NDIG (16/4 gives 4 cycles).
- Minimum initiation interval is NDIG+2 cycles: NDIG in RUN, 1 in DONE with out_ready=1, 1 in IDLE.
- in_ready depends only on state, not on in_valid.
- out_valid depends only on state, not on out_ready.
- If out_ready is already high on entry to DONE, the result is consumed in that cycle.

## Configuration
SEQ_ADD_OVF_EN:
- Defined: the overflow port exists. During the last RUN cycle the block registers (carry into MSB) XOR (carry out of MSB), i.e. the signed overflow of a+b+cin or a−b. The flag is valid with out_valid.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package seq_add_pkg: the state enum (IDLE, RUN, DONE) and a function for the counter width, clog2 of NDIG with a minimum of 1.
- Sub-module digit_add: combinational DIGIT-bit adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and msb_cin for the overflow logic.
  - Instantiated once and muxed by cnt.

## Test plan
Bench parameters WIDTH=16, DIGIT=4 unless noted.
- Basic add: a=0x1234, b=0x4321, sub=0, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x5555, carry_out=0.
- Cross-digit carry: a=0x000F, b=0x0000, cin=1 -> sum=0x0010. Then a=0xFFFF, b=0x0001 -> sum=0x0000, carry_out=1, overflow=0.
- Signed overflow (SEQ_ADD_OVF_EN defined): a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, carry_out=0. Then a=0x0007, b=0x0005 -> sum=0x0002, carry_out=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid with new operands -> sum is stable, in_ready=0, and nothing is accepted. Raise out_ready -> IDLE next cycle, then the pending beat is accepted.
- Reset mid-RUN, plus DIGIT=WIDTH=8:
  - Deassert rst_n in the 2nd RUN cycle -> outputs return to their reset values immediately and the next operation computes correctly.
  - With WIDTH=8, DIGIT=8: 0x80+0x80 -> sum=0x00, carry_out=1, latency 1 cycle.
